// File: rtl/f1_pkg.sv
// f1_pkg: shared definitions for the F1 start-light sequencer.
//   - FSM state encodings (legacy constants) and the f1_state_t enum built on them
//   - LFSR tap mask and seed
//   - thermometer-code helper
package f1_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_COUNT = 3'd1;
  localparam logic [2:0] S_HOLD  = 3'd2;
  localparam logic [2:0] S_REACT = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = S_IDLE,
    ST_COUNT = S_COUNT,
    ST_HOLD  = S_HOLD,
    ST_REACT = S_REACT,
    ST_DONE  = S_DONE
  } f1_state_t;

  // Fibonacci taps 16,14,13,11 -> register bits 15,13,12,10.
  localparam logic [15:0] F1_LFSR_TAPS = 16'hB400;
  localparam logic [15:0] F1_LFSR_SEED = 16'h0001;

  function automatic logic [15:0] f1_lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & F1_LFSR_TAPS)};
  endfunction

  // k ones from bit 0; k >= 32 gives all ones.
  function automatic logic [31:0] f1_thermo(input logic [5:0] k);
    logic [31:0] v;
    v = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (32'(k) > i) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/f1_start_seq_tick_gen.sv
// tick_gen: sequencer tick generator.
//   clk  in  : clock
//   rst  in  : asynchronous active-high reset
//   clr  in  : synchronous counter clear (wins over en)
//   en   in  : count enable
//   tick out : one-cycle pulse every TICK_CYCLES enabled cycles
module tick_gen #(
  parameter int unsigned TICK_CYCLES = 48
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = $clog2(TICK_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      if (r_cnt == LAST) r_cnt <= '0;
      else               r_cnt <= r_cnt + CW'(1);
    end
  end

  assign tick = en & ~clr & (r_cnt == LAST);

endmodule

// File: rtl/f1_start_seq.sv
// f1_start_seq: F1 start-light sequencer with random hold and reaction timer.
//   clk        in  : clock, rising edge
//   rst        in  : asynchronous active-high reset
//   trigger    in  : start request (IDLE/DONE only)
//   react      in  : driver button
//   lights     out : lamp thermometer, bit 0 lit first
//   busy       out : high in COUNT, HOLD, REACT
//   rt_valid   out : result available (DONE)
//   rt         out : reaction time in cycles, saturating
//   jump_start out : result was a jump start
module f1_start_seq
  import f1_pkg::*;
#(
  parameter int unsigned N_LIGHTS    = 8,
  parameter int unsigned TICK_CYCLES = 48,
  parameter int unsigned DELAY_MIN   = 2,
  parameter int unsigned DELAY_BITS  = 4,
  parameter int unsigned RT_WIDTH    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                trigger,
  input  logic                react,
  output logic [N_LIGHTS-1:0] lights,
  output logic                busy,
  output logic                rt_valid,
  output logic [RT_WIDTH-1:0] rt,
  output logic                jump_start
);

  localparam int unsigned KW     = $clog2(N_LIGHTS + 1);
  localparam int unsigned HOLD_W = $clog2(DELAY_MIN + (1 << DELAY_BITS));

  f1_state_t           r_state;
  logic [KW-1:0]       r_k;
  logic [HOLD_W-1:0]   r_hold;
  logic [RT_WIDTH-1:0] r_rt;
  logic                r_jump;
  logic [15:0]         r_lfsr;

  logic w_tick;
  logic w_start;
  logic w_en;

  assign w_start = trigger & ((r_state == ST_IDLE) | (r_state == ST_DONE));
  assign w_en    = (r_state == ST_COUNT) | (r_state == ST_HOLD);

  tick_gen #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_start),
    .en   (w_en),
    .tick (w_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_k     <= '0;
      r_hold  <= '0;
      r_rt    <= '0;
      r_jump  <= 1'b0;
      r_lfsr  <= F1_LFSR_SEED;
    end else begin
      r_lfsr <= f1_lfsr_next(r_lfsr);
      case (r_state)
        ST_IDLE, ST_DONE: begin
          // trigger takes priority; react is ignored here
          if (trigger) begin
            r_state <= ST_COUNT;
            r_k     <= '0;
            r_rt    <= '0;
            r_jump  <= 1'b0;
          end
        end
        ST_COUNT: begin
          // react beats a coincident tick
          if (react) begin
            r_state <= ST_DONE;
            r_rt    <= '0;
            r_jump  <= 1'b1;
          end else if (w_tick) begin
            r_k <= r_k + KW'(1);
            if (r_k == KW'(N_LIGHTS - 1)) begin
              r_state <= ST_HOLD;
              r_hold  <= HOLD_W'(DELAY_MIN) + HOLD_W'(r_lfsr[DELAY_BITS-1:0]);
            end
          end
        end
        ST_HOLD: begin
          if (react) begin
            r_state <= ST_DONE;
            r_rt    <= '0;
            r_jump  <= 1'b1;
          end else if (w_tick) begin
            r_hold <= r_hold - HOLD_W'(1);
            if (r_hold == HOLD_W'(1)) begin
              r_state <= ST_REACT;
              r_rt    <= '0;
            end
          end
        end
        ST_REACT: begin
          if (react) begin
            r_state <= ST_DONE;
            r_jump  <= 1'b0;
          end else if (r_rt != '1) begin
            r_rt <= r_rt + RT_WIDTH'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    lights = '0;
    case (r_state)
      ST_COUNT: lights = N_LIGHTS'(f1_thermo(6'(r_k)));
      ST_HOLD:  lights = '1;
      default:  lights = '0;
    endcase
  end

  assign busy       = (r_state == ST_COUNT) | (r_state == ST_HOLD) | (r_state == ST_REACT);
  assign rt_valid   = (r_state == ST_DONE);
  assign rt         = r_rt;
  assign jump_start = r_jump;

endmodule

// File: tb/tb_f1_start_seq.sv
module tb_f1_start_seq;

  localparam int N      = 8;
  localparam int TC     = 4;
  localparam int DMIN   = 2;
  localparam int DB     = 4;
  localparam int RTW    = 4;
  localparam int RT_MAX = (1 << RTW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic trigger = 1'b0;
  logic react = 1'b0;
  logic [N-1:0]   lights;
  logic           busy;
  logic           rt_valid;
  logic [RTW-1:0] rt;
  logic           jump_start;

  f1_start_seq #(
    .N_LIGHTS(N), .TICK_CYCLES(TC), .DELAY_MIN(DMIN),
    .DELAY_BITS(DB), .RT_WIDTH(RTW)
  ) dut (
    .clk(clk), .rst(rst), .trigger(trigger), .react(react),
    .lights(lights), .busy(busy), .rt_valid(rt_valid),
    .rt(rt), .jump_start(jump_start)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Number of rising edges since reset was released.
  int edge_n;
  always @(posedge clk or posedge rst) begin
    if (rst) edge_n <= 0;
    else     edge_n <= edge_n + 1;
  end

  typedef struct { int rt; bit jump; int done_edge; } exp_t;
  typedef struct { bit active; int t; int h; int l; int r; } txn_t;

  exp_t sb_q[$];
  txn_t cur = '{0, 0, 0, 0, 0};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, expv, edge_n);
    end
  endtask

  function automatic logic [15:0] lfsr_after(input int n);
    logic [15:0] s;
    s = 16'h0001;
    for (int i = 0; i < n; i++) s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    return s;
  endfunction

  function automatic logic [N-1:0] thermo(input int k);
    int v;
    v = (1 << k) - 1;
    return v[N-1:0];
  endfunction

  // Per-cycle output model, derived from the edge timeline of the current run.
  always @(negedge clk) begin
    int e;
    if (!rst) begin
      e = edge_n;
      if (!cur.active) begin
        chk("idle_lights", lights, 0);
        chk("idle_busy", busy, 0);
        chk("idle_rt_valid", rt_valid, 0);
        chk("idle_rt", rt, 0);
        chk("idle_jump", jump_start, 0);
      end else if (e < cur.r) begin
        chk("run_busy", busy, 1);
        chk("run_rt_valid", rt_valid, 0);
        if (e < cur.h)      chk("count_lights", lights, thermo((e - cur.t) / TC));
        else if (e < cur.l) chk("hold_lights", lights, {N{1'b1}});
        else begin
          chk("react_lights", lights, 0);
          chk("react_rt", rt, (e - cur.l) > RT_MAX ? RT_MAX : (e - cur.l));
        end
      end else begin
        chk("done_lights", lights, 0);
        chk("done_busy", busy, 0);
        chk("done_rt_valid", rt_valid, 1);
      end
    end
  end

  // Result monitor: pops the scoreboard on each rt_valid rise.
  bit prev_v = 1'b0;
  always @(negedge clk) begin
    exp_t x;
    if (rst) prev_v = 1'b0;
    else begin
      if (rt_valid && !prev_v) begin
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_result: got rt_valid with no expected entry (edge %0d)", edge_n);
        end else begin
          x = sb_q.pop_front();
          chk("result_rt", rt, x.rt);
          chk("result_jump", jump_start, x.jump);
          chk("result_edge", edge_n, x.done_edge);
        end
      end
      prev_v = rt_valid;
    end
  end

  task automatic wait_until(input int e);
    while (edge_n < e) begin
      @(posedge clk); #1;
    end
  endtask

  // mode 0: react after param low REACT cycles; mode 1: react at edge T+param
  // (param<0 picks a random jump point); mode 2: retrigger with react held.
  task automatic run_txn(input int mode, input int param);
    int t, h, r, l, rr;
    logic [15:0] lf;
    exp_t x;
    trigger = 1'b1;
    if (mode == 2) react = 1'b1;
    @(posedge clk); #1;
    trigger = 1'b0;
    t  = edge_n;
    h  = t + N * TC;
    lf = lfsr_after(h - 1);
    r  = int'(lf[DB-1:0]);
    l  = h + (DMIN + r) * TC;
    if (mode == 0) begin
      rr = l + param + 1;
      x  = '{(param > RT_MAX) ? RT_MAX : param, 1'b0, rr};
    end else begin
      rr = (param < 0) ? t + int'($urandom_range(1, l - t)) : t + param;
      x  = '{0, 1'b1, rr};
    end
    cur = '{1'b1, t, h, l, rr};
    sb_q.push_back(x);
    if (mode != 2) begin
      wait_until(rr - 1);
      react = 1'b1;
    end
    wait_until(rr);
    react = 1'b0;
    wait_until(rr + 2);
  endtask

  task automatic reset_mid_run();
    int t;
    trigger = 1'b1;
    @(posedge clk); #1;
    trigger = 1'b0;
    t = edge_n;
    cur = '{1'b1, t, t + N * TC, t + N * TC + 1000, t + 100000};
    wait_until(t + 5 * TC);
    chk("lamp5_lights", lights, 8'h1F);
    cur.active = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_lights", lights, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rt_valid", rt_valid, 0);
    chk("rst_rt", rt, 0);
    chk("rst_jump", jump_start, 0);
    @(negedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    repeat (50) begin
      @(posedge clk); #1;
      chk("idle_lfsr", dut.r_lfsr, lfsr_after(edge_n));
    end
    run_txn(0, 10);            // full run, rt = 10
    run_txn(1, N * TC + 2);    // jump start during HOLD
    run_txn(1, 3 * TC + 2);    // jump start at k = 3
    run_txn(0, 40);            // never reacts in time: rt saturates
    run_txn(2, 1);             // retrigger from DONE with react held
    repeat (6) begin
      if ($urandom_range(0, 1) == 0) run_txn(0, int'($urandom_range(0, 20)));
      else                           run_txn(1, -1);
    end
    reset_mid_run();
    run_txn(0, 5);             // restart after reset from lamp 0
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
